// File: rtl/proc_test_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : proc_test_pkg
//  Description : Shared types and constants for the processor write monitor:
//                FSM state encoding, run status codes and the saturating
//                increment used by the store counter.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package proc_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TOUT = 3'd4
    } monState_t;

    localparam logic [1:0] STAT_BUSY = 2'd0;
    localparam logic [1:0] STAT_PASS = 2'd1;
    localparam logic [1:0] STAT_FAIL = 2'd2;
    localparam logic [1:0] STAT_TOUT = 2'd3;

    localparam logic [15:0] c_WR_COUNT_MAX = 16'hFFFF;

    // Store counter sticks at all-ones rather than wrapping to zero.
    function automatic logic [15:0] satInc16(input logic [15:0] v);
        return (v == c_WR_COUNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_write_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : proc_write_monitor_if
//  Description : Bundle of the monitor's control, store-bus, log-read and
//                result signals.
//  Ports       : master - drives start/targets, the store bus and rd_en
//                slave  - the monitor; drives log read port and results
//  Revision    : 1.0 - initial release
// ============================================================================
interface proc_write_monitor_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LOG_DEPTH = 8
);
    localparam int c_LCNT_W = $clog2(LOG_DEPTH) + 1;

    logic              start;
    logic [ADDR_W-1:0] target_adr;
    logic [DATA_W-1:0] target_data;
    logic              MemWrite;
    logic [ADDR_W-1:0] DataAdr;
    logic [DATA_W-1:0] WriteData;
    logic              rd_en;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_adr;
    logic [DATA_W-1:0] rd_data;
    logic [c_LCNT_W-1:0] log_count;
    logic              overflow;
    logic [1:0]        status;
    logic              done;
    logic [15:0]       wr_count;

    modport master (
        output start, target_adr, target_data, MemWrite, DataAdr, WriteData, rd_en,
        input  rd_valid, rd_adr, rd_data, log_count, overflow, status, done, wr_count
    );

    modport slave (
        input  start, target_adr, target_data, MemWrite, DataAdr, WriteData, rd_en,
        output rd_valid, rd_adr, rd_data, log_count, overflow, status, done, wr_count
    );

endinterface
`default_nettype wire

// File: rtl/wr_log_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wr_log_fifo
//  Description : First-word fall-through log of observed stores. A push into
//                a full log is dropped and sets a sticky overflow flag, except
//                when a pop happens in the same cycle.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                i_clr           - synchronous clear (highest priority)
//                i_push/i_pushData, i_pop - write and read strobes
//                o_valid/o_rdData - oldest entry (zero when empty)
//                o_count, o_overflow - occupancy and dropped-push flag
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_log_fifo #(
    parameter int WIDTH     = 64,
    parameter int LOG_DEPTH = 8
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         i_clr,
    input  wire logic                         i_push,
    input  wire logic [WIDTH-1:0]             i_pushData,
    input  wire logic                         i_pop,
    output logic                              o_valid,
    output logic [WIDTH-1:0]                  o_rdData,
    output logic [$clog2(LOG_DEPTH):0]        o_count,
    output logic                              o_overflow
);
    localparam int                  c_PTR_W = $clog2(LOG_DEPTH);
    localparam logic [c_PTR_W:0]    c_FULL  = (c_PTR_W + 1)'(LOG_DEPTH);

    logic [WIDTH-1:0]   r_mem [LOG_DEPTH];
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W:0]   r_count;
    logic               r_overflow;

    logic w_empty;
    logic w_full;
    logic w_popOk;
    logic w_pushOk;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign w_popOk  = i_pop && !w_empty;
    // A simultaneous pop frees a slot, so a push into a full log still fits.
    assign w_pushOk = i_push && (!w_full || w_popOk);

    // Pointers wrap naturally because LOG_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clr) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_popOk)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_pushOk, w_popOk})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && !w_pushOk) r_overflow <= 1'b1;
        end
    end

    // Storage carries no reset; its contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (w_pushOk && !i_clr) r_mem[r_wrPtr] <= i_pushData;
    end

    assign o_valid    = !w_empty;
    assign o_rdData   = w_empty ? '0 : r_mem[r_rdPtr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/proc_write_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : proc_write_monitor
//  Description : Watches a processor store bus for a write of an expected
//                value to an expected address. Reports pass, fail (right
//                address, wrong data) or timeout, counts stores and logs them.
//  Ports       : CLK   - clock, rising edge
//                reset - asynchronous active-low reset
//                mon   - slave side of proc_write_monitor_if (start/targets,
//                        store bus, log read port, status/done/wr_count)
//  Revision    : 1.0 - initial release
// ============================================================================
module proc_write_monitor
    import proc_test_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LOG_DEPTH = 8,
    parameter int TIMEOUT   = 1024
) (
    input  wire logic            CLK,
    input  wire logic            reset,
    proc_write_monitor_if.slave  mon
);
    localparam int                   c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam int                   c_ENTRY_W  = ADDR_W + DATA_W;

    monState_t          r_state;
    logic [ADDR_W-1:0]  r_tgtAdr;
    logic [DATA_W-1:0]  r_tgtData;
    logic [c_CNT_W-1:0] r_cycleCnt;
    logic [15:0]        r_wrCount;
    logic [1:0]         r_status;
    logic               r_done;

    logic                 w_storeInRun;
    logic                 w_hit;
    logic                 w_push;
    logic [c_ENTRY_W-1:0] w_rdEntry;

    assign w_storeInRun = (r_state == ST_RUN) && mon.MemWrite;
    assign w_hit        = w_storeInRun && (mon.DataAdr == r_tgtAdr);
    // start clears the log, so a store in the same cycle must not land in it.
    assign w_push       = w_storeInRun && !mon.start;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_tgtAdr   <= '0;
            r_tgtData  <= '0;
            r_cycleCnt <= '0;
            r_wrCount  <= '0;
            r_status   <= STAT_BUSY;
            r_done     <= 1'b0;
        end else if (mon.start) begin
            r_state    <= ST_RUN;
            r_tgtAdr   <= mon.target_adr;
            r_tgtData  <= mon.target_data;
            r_cycleCnt <= '0;
            r_wrCount  <= '0;
            r_status   <= STAT_BUSY;
            r_done     <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (mon.MemWrite) r_wrCount <= satInc16(r_wrCount);
            // A deciding write wins over a timeout landing in the same cycle.
            if (w_hit) begin
                r_done <= 1'b1;
                if (mon.WriteData == r_tgtData) begin
                    r_state  <= ST_PASS;
                    r_status <= STAT_PASS;
                end else begin
                    r_state  <= ST_FAIL;
                    r_status <= STAT_FAIL;
                end
            end else if (r_cycleCnt == c_CNT_LAST) begin
                r_state  <= ST_TOUT;
                r_status <= STAT_TOUT;
                r_done   <= 1'b1;
            end else begin
                r_cycleCnt <= r_cycleCnt + 1'b1;
            end
        end
    end

    wr_log_fifo #(
        .WIDTH     (c_ENTRY_W),
        .LOG_DEPTH (LOG_DEPTH)
    ) u_log (
        .clk        (CLK),
        .rst_n      (reset),
        .i_clr      (mon.start),
        .i_push     (w_push),
        .i_pushData ({mon.DataAdr, mon.WriteData}),
        .i_pop      (mon.rd_en),
        .o_valid    (mon.rd_valid),
        .o_rdData   (w_rdEntry),
        .o_count    (mon.log_count),
        .o_overflow (mon.overflow)
    );

    assign mon.rd_adr   = w_rdEntry[c_ENTRY_W-1 -: ADDR_W];
    assign mon.rd_data  = w_rdEntry[DATA_W-1:0];
    assign mon.status   = r_status;
    assign mon.done     = r_done;
    assign mon.wr_count = r_wrCount;

endmodule
`default_nettype wire

// File: doc/proc_write_monitor.md
PROC_WRITE_MONITOR -- requirements
Module: proc_write_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of the monitored data address.
REQ-002 SHALL have parameter DATA_W, default 32: width of the monitored write data.
REQ-003 SHALL have parameter LOG_DEPTH, default 8 (power of 2, >=2): number of entries in the write log.
REQ-004 SHALL have parameter TIMEOUT, default 1024: cycles in RUN before the monitor declares timeout.
REQ-005 SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1: one-cycle pulse that arms a new run.
REQ-008 SHALL have ports target_adr (input, ADDR_W) and target_data (input, DATA_W): pass criterion, sampled on start.
REQ-009 SHALL have ports MemWrite (input, 1), DataAdr (input, ADDR_W) and WriteData (input, DATA_W): processor store bus.
REQ-010 SHALL have ports rd_en (input, 1), rd_valid (output, 1), rd_adr (output, ADDR_W) and rd_data (output, DATA_W): log read port, first-word fall-through.
REQ-011 SHALL have ports log_count (output, $clog2(LOG_DEPTH)+1) and overflow (output, 1, sticky): log occupancy and dropped-entry flag.
REQ-012 SHALL have ports status (output, 2; 0=busy/idle, 1=pass, 2=fail, 3=timeout), done (output, 1) and wr_count (output, 16): run result and number of stores seen.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, PASS, FAIL, TOUT.
REQ-014 SHALL go from any state to RUN on start, latching target_adr and target_data and clearing the cycle counter, wr_count, the log, overflow and status.
REQ-015 SHALL, in RUN, on a MemWrite with DataAdr==latched target: go to PASS if WriteData matches the latched data, else go to FAIL.
REQ-016 SHALL, in RUN, go to TOUT when the cycle counter reaches TIMEOUT-1 with no deciding write.
REQ-017 SHALL give a deciding write priority over timeout in the same cycle.
REQ-018 SHALL update status and done the cycle after the deciding sample: 1-cycle latency, registered outputs.
REQ-019 SHALL hold done high in PASS, FAIL and TOUT until the next start or reset.
REQ-020 SHALL, in RUN only, increment wr_count (saturating at 16'hFFFF) and push {DataAdr,WriteData} into the log on every MemWrite, including the deciding write.
REQ-021 SHALL, with the log full, drop the push and set overflow, unless rd_en pops in the same cycle; in that case the push is accepted.
REQ-022 SHALL keep rd_valid = log non-empty; rd_adr/rd_data show the oldest entry; rd_en with an empty log is ignored.
REQ-023 SHALL wrap the log pointers modulo LOG_DEPTH; log_count ranges 0..LOG_DEPTH.
REQ-024 SHALL ignore MemWrite outside RUN, while the log stays readable in every state.
REQ-025 SHALL let start take precedence over a simultaneous MemWrite or rd_en.

Reset
REQ-026 SHALL, while reset=0, force the following immediately: state IDLE, status 0, done 0, wr_count 0, log_count 0, rd_valid 0, overflow 0, cycle counter 0, latched targets 0.
REQ-027 SHALL abort a run when reset is asserted mid-run, with no partial result retained.

Structure
REQ-028 SHALL place the FSM state encoding and the status code constants (STAT_BUSY, STAT_PASS, STAT_FAIL, STAT_TOUT) in shared package proc_test_pkg.
REQ-029 SHALL implement the log as sub-module wr_log_fifo, parametrised by width (ADDR_W+DATA_W) and LOG_DEPTH.

Verification
REQ-030 SHALL cover: start with target 84/7, then stores (80,3), (84,7) -> status=1 and done=1 one cycle after the second store, wr_count=2, log holds 2 entries in order.
REQ-031 SHALL cover: target 84/7, then store (84,5) -> status=2, and later stores do not change wr_count.
REQ-032 SHALL cover: TIMEOUT=16 with no stores -> status=3 exactly 16 cycles after start; a matching store on cycle 16 instead -> status=1.
REQ-033 SHALL cover: LOG_DEPTH=4 with 5 stores to non-target addresses -> overflow=1, log_count=4; a 6th store with rd_en in the same cycle is accepted.
REQ-034 SHALL cover: reset dropped low mid-run after 3 stores -> all outputs zero asynchronously; a new start then runs cleanly.
REQ-035 SHALL cover: start asserted in PASS -> done=0 and log_count=0 on the next cycle, and a new run begins.
